// File: rtl/core_control_fsm_pkg.sv
// Shared types and constants for the RV32I multi-cycle control sequencer:
// FSM states, opcode values, mux select encodings and instruction classes.
package core_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADR, S_MEMREAD,
        S_MEMWB, S_MEMWRITE, S_BRANCH, S_JAL, S_JALR, S_HALT
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_TARGET = 2'b01,
        PC_ALU    = 2'b10
    } pc_src_t;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_MEM  = 2'b01,
        RES_PC4  = 2'b10
    } result_src_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [2:0] {
        CLS_NONE, CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_JALR
    } instr_class_t;

    // Only beq/bne are supported; every other funct3 falls through.
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
        return ((f3 == F3_BEQ) && zero) || ((f3 == F3_BNE) && !zero);
    endfunction

endpackage

// File: rtl/core_control_fsm_if.sv
// Shared instruction/data memory port handshake between the control FSM
// (master) and the memory (slave).
interface core_control_fsm_if;
    logic mem_req;
    logic mem_we;
    logic adr_src;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output adr_src, input mem_ready);
    modport slave  (input mem_req, input mem_we, input adr_src, output mem_ready);
endinterface

// File: rtl/core_control_fsm_instr_class_decode.sv
// Combinational opcode classifier; flags any opcode outside the supported set.
module instr_class_decode
    import core_ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_t cls,
    output logic         illegal
);
    always_comb begin
        cls     = CLS_NONE;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE:  cls = CLS_R;
            OP_ITYPE:  cls = CLS_I;
            OP_LOAD:   cls = CLS_LOAD;
            OP_STORE:  cls = CLS_STORE;
            OP_BRANCH: cls = CLS_BRANCH;
            OP_JAL:    cls = CLS_JAL;
            OP_JALR:   cls = CLS_JALR;
            default:   illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/core_control_fsm.sv
// Multi-cycle RV32I control sequencer with memory-wait timeout and sticky halt.
// Optional feature macro: ILLEGAL_TRAP_EN (undefined opcodes halt instead of NOP).
module core_control_fsm
    import core_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                zero,
    core_control_fsm_if.master  mem,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                reg_write,
    output logic [1:0]          result_src,
    output logic                alu_src_b,
    output logic [1:0]          alu_op,
    output logic                halted,
    output logic                mem_timeout,
    output logic                illegal
);
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

    state_t       state_q, state_d;
    logic [7:0]   wait_q, wait_d;
    logic         timeout_q, timeout_d;
    instr_class_t cls;
    logic         dec_illegal;
    logic         req_c, we_c, adr_c;
    pc_src_t      pc_src_c;
    result_src_t  result_src_c;

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
`endif

    instr_class_decode u_decode (
        .opcode  (opcode),
        .cls     (cls),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            timeout_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_d       = '0;
        timeout_d    = timeout_q;
`ifdef ILLEGAL_TRAP_EN
        illegal_d    = illegal_q;
`endif
        req_c        = 1'b0;
        we_c         = 1'b0;
        adr_c        = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src_c     = PC_PLUS4;
        reg_write    = 1'b0;
        result_src_c = RES_ALU;
        alu_src_b    = 1'b0;
        alu_op       = ALU_ADD;
        halted       = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                req_c = 1'b1;
                if (mem.mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                case (cls)
                    CLS_R, CLS_I:        state_d = S_EXEC;
                    CLS_LOAD, CLS_STORE: state_d = S_MEMADR;
                    CLS_BRANCH:          state_d = S_BRANCH;
                    CLS_JAL:             state_d = S_JAL;
                    CLS_JALR:            state_d = S_JALR;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
`else
                        state_d   = S_ALUWB;
`endif
                    end
                endcase
            end
            S_EXEC: begin
                alu_op    = ALU_FUNCT;
                alu_src_b = (cls == CLS_I);
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                // Unknown opcodes retire here as a NOP: PC advances, no register write.
                reg_write = !dec_illegal;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMADR: begin
                alu_src_b = 1'b1;
                state_d   = (cls == CLS_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                req_c = 1'b1;
                adr_c = 1'b1;
                if (mem.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write    = 1'b1;
                result_src_c = RES_MEM;
                pc_write     = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                req_c = 1'b1;
                we_c  = 1'b1;
                adr_c = 1'b1;
                if (mem.mem_ready) begin
                    pc_write = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_op   = ALU_SUB;
                pc_write = 1'b1;
                pc_src_c = branch_taken(funct3, zero) ? PC_TARGET : PC_PLUS4;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                reg_write    = 1'b1;
                result_src_c = RES_PC4;
                pc_write     = 1'b1;
                pc_src_c     = PC_TARGET;
                state_d      = S_FETCH;
            end
            S_JALR: begin
                alu_src_b    = 1'b1;
                reg_write    = 1'b1;
                result_src_c = RES_PC4;
                pc_write     = 1'b1;
                pc_src_c     = PC_ALU;
                state_d      = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            default: state_d = S_HALT;
        endcase

        // A ready arriving on the last allowed wait cycle still completes the access.
        if (req_c && !mem.mem_ready) begin
            if (wait_q == WAIT_LAST) begin
                state_d   = S_HALT;
                timeout_d = 1'b1;
            end else if (wait_q != 8'hFF) begin
                wait_d = wait_q + 8'd1;
            end
        end
    end

    assign mem.mem_req  = req_c;
    assign mem.mem_we   = we_c;
    assign mem.adr_src  = adr_c;
    assign pc_src       = pc_src_c;
    assign result_src   = result_src_c;
    assign mem_timeout  = timeout_q;
`ifdef ILLEGAL_TRAP_EN
    assign illegal      = illegal_q;
`else
    assign illegal      = 1'b0;
`endif
endmodule

// File: tb/tb_core_control_fsm.sv
// Directed per-cycle vector bench for core_control_fsm (WAIT_LIMIT=4), plus
// hand-written timeout, asynchronous-reset and illegal-opcode sequences.
module tb_core_control_fsm;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_J  = 7'b1101111;
    localparam logic [6:0] OP_JR = 7'b1100111;
    localparam logic [6:0] OP_BAD = 7'b0000000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       zero = 1'b0;
    logic       ir_write, pc_write, reg_write, alu_src_b, halted, mem_timeout, illegal;
    logic [1:0] pc_src, result_src, alu_op;

    core_control_fsm_if mem_bus ();

    core_control_fsm #(.WAIT_LIMIT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .funct3      (funct3),
        .zero        (zero),
        .mem         (mem_bus.master),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .reg_write   (reg_write),
        .result_src  (result_src),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .halted      (halted),
        .mem_timeout (mem_timeout),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // {req, we, adr, ir, pcw, pc_src[2], rw, result_src[2], alu_src_b, alu_op[2], halted, timeout, illegal}
    logic [15:0] act;
    assign act = {mem_bus.mem_req, mem_bus.mem_we, mem_bus.adr_src, ir_write, pc_write,
                  pc_src, reg_write, result_src, alu_src_b, alu_op, halted, mem_timeout, illegal};

    typedef struct {
        string       name;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        z;
        logic        rdy;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [15:0] E(input logic req, we, adr, ir, pcw, input logic [1:0] pcs,
                                      input logic rw, input logic [1:0] rs, input logic asb,
                                      input logic [1:0] aop, input logic h, to, il);
        return {req, we, adr, ir, pcw, pcs, rw, rs, asb, aop, h, to, il};
    endfunction

    function automatic void add(input string nm, input logic [6:0] opc, input logic [2:0] f3,
                                input logic z, input logic rdy, input logic [15:0] exp);
        vec_t v;
        v.name = nm; v.opc = opc; v.f3 = f3; v.z = z; v.rdy = rdy; v.exp = exp;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end else begin
            $display("vec %0d %s out=%b", n_vec, nm, act);
        end
    endtask

    // Drive one cycle's inputs, check just after, then move to the next falling edge.
    task automatic step(input string nm, input logic [6:0] opc, input logic [2:0] f3,
                        input logic z, input logic rdy, input logic [15:0] exp);
        opcode = opc; funct3 = f3; zero = z; mem_bus.mem_ready = rdy;
        #1;
        chk(nm, exp);
        @(negedge clk);
    endtask

    logic [15:0] Z, FET, FET_W, DEC, EXR, EXI, WB, WB_NOP, MADR, MRD, MWB, MWR_W, MWR_OK;
    logic [15:0] BR_T, BR_N, JAL_E, JALR_E, HALT_TO, HALT_IL;

    initial begin
        Z       = '0;
        FET     = E(1,0,0,1,0,2'b00,0,2'b00,0,2'b00,0,0,0);
        FET_W   = E(1,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,0,0);
        DEC     = Z;
        EXR     = E(0,0,0,0,0,2'b00,0,2'b00,0,2'b10,0,0,0);
        EXI     = E(0,0,0,0,0,2'b00,0,2'b00,1,2'b10,0,0,0);
        WB      = E(0,0,0,0,1,2'b00,1,2'b00,0,2'b00,0,0,0);
        WB_NOP  = E(0,0,0,0,1,2'b00,0,2'b00,0,2'b00,0,0,0);
        MADR    = E(0,0,0,0,0,2'b00,0,2'b00,1,2'b00,0,0,0);
        MRD     = E(1,0,1,0,0,2'b00,0,2'b00,0,2'b00,0,0,0);
        MWB     = E(0,0,0,0,1,2'b00,1,2'b01,0,2'b00,0,0,0);
        MWR_W   = E(1,1,1,0,0,2'b00,0,2'b00,0,2'b00,0,0,0);
        MWR_OK  = E(1,1,1,0,1,2'b00,0,2'b00,0,2'b00,0,0,0);
        BR_T    = E(0,0,0,0,1,2'b01,0,2'b00,0,2'b01,0,0,0);
        BR_N    = E(0,0,0,0,1,2'b00,0,2'b00,0,2'b01,0,0,0);
        JAL_E   = E(0,0,0,0,1,2'b01,1,2'b10,0,2'b00,0,0,0);
        JALR_E  = E(0,0,0,0,1,2'b10,1,2'b10,1,2'b00,0,0,0);
        HALT_TO = E(0,0,0,0,0,2'b00,0,2'b00,0,2'b00,1,1,0);
        HALT_IL = E(0,0,0,0,0,2'b00,0,2'b00,0,2'b00,1,0,1);

        add("idle",       OP_R,  3'b000, 0, 1, Z);
        add("r_fetch",    OP_R,  3'b000, 0, 1, FET);
        add("r_decode",   OP_R,  3'b000, 0, 1, DEC);
        add("r_exec",     OP_R,  3'b000, 0, 1, EXR);
        add("r_wb",       OP_R,  3'b000, 0, 1, WB);
        add("beq_fetch",  OP_B,  3'b000, 1, 1, FET);
        add("beq_decode", OP_B,  3'b000, 1, 1, DEC);
        add("beq_z1",     OP_B,  3'b000, 1, 1, BR_T);
        add("bne_fetch",  OP_B,  3'b001, 1, 1, FET);
        add("bne_decode", OP_B,  3'b001, 1, 1, DEC);
        add("bne_z1",     OP_B,  3'b001, 1, 1, BR_N);
        add("beq_fetch2", OP_B,  3'b000, 0, 1, FET);
        add("beq_dec2",   OP_B,  3'b000, 0, 1, DEC);
        add("beq_z0",     OP_B,  3'b000, 0, 1, BR_N);
        add("bne_fetch2", OP_B,  3'b001, 0, 1, FET);
        add("bne_dec2",   OP_B,  3'b001, 0, 1, DEC);
        add("bne_z0",     OP_B,  3'b001, 0, 1, BR_T);
        add("blt_fetch",  OP_B,  3'b100, 1, 1, FET);
        add("blt_decode", OP_B,  3'b100, 1, 1, DEC);
        add("blt_other",  OP_B,  3'b100, 1, 1, BR_N);
        add("i_fetch",    OP_I,  3'b000, 0, 1, FET);
        add("i_decode",   OP_I,  3'b000, 0, 1, DEC);
        add("i_exec",     OP_I,  3'b000, 0, 1, EXI);
        add("i_wb",       OP_I,  3'b000, 0, 1, WB);
        add("lw_fetch",   OP_LW, 3'b010, 0, 1, FET);
        add("lw_decode",  OP_LW, 3'b010, 0, 1, DEC);
        add("lw_memadr",  OP_LW, 3'b010, 0, 1, MADR);
        add("lw_wait1",   OP_LW, 3'b010, 0, 0, MRD);
        add("lw_wait2",   OP_LW, 3'b010, 0, 0, MRD);
        add("lw_wait3",   OP_LW, 3'b010, 0, 0, MRD);
        add("lw_ready",   OP_LW, 3'b010, 0, 1, MRD);
        add("lw_memwb",   OP_LW, 3'b010, 0, 1, MWB);
        add("sw_fwait",   OP_SW, 3'b010, 0, 0, FET_W);
        add("sw_fetch",   OP_SW, 3'b010, 0, 1, FET);
        add("sw_decode",  OP_SW, 3'b010, 0, 1, DEC);
        add("sw_memadr",  OP_SW, 3'b010, 0, 1, MADR);
        add("sw_wait1",   OP_SW, 3'b010, 0, 0, MWR_W);
        add("sw_wait2",   OP_SW, 3'b010, 0, 0, MWR_W);
        add("sw_wait3",   OP_SW, 3'b010, 0, 0, MWR_W);
        add("sw_ready_lim", OP_SW, 3'b010, 0, 1, MWR_OK);
        add("jal_fetch",  OP_J,  3'b000, 0, 1, FET);
        add("jal_decode", OP_J,  3'b000, 0, 1, DEC);
        add("jal",        OP_J,  3'b000, 0, 1, JAL_E);
        add("jalr_fetch", OP_JR, 3'b000, 0, 1, FET);
        add("jalr_decode", OP_JR, 3'b000, 0, 1, DEC);
        add("jalr",       OP_JR, 3'b000, 0, 1, JALR_E);

        mem_bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", Z);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i])
            step(vecs[i].name, vecs[i].opc, vecs[i].f3, vecs[i].z, vecs[i].rdy, vecs[i].exp);

        // Fetch stalls: four wait cycles with WAIT_LIMIT=4 then sticky halt.
        for (int k = 0; k < 4; k++) step("to_wait", OP_R, 3'b000, 0, 0, FET_W);
        step("to_halt",  OP_R, 3'b000, 0, 1, HALT_TO);
        step("to_stuck", OP_R, 3'b000, 0, 1, HALT_TO);
        reset = 1'b1;
        #1;
        chk("to_reset_clear", Z);
        @(negedge clk);
        reset = 1'b0;

        // Asynchronous reset during a pending fetch drops mem_req immediately.
        step("ra_idle",  OP_R, 3'b000, 0, 0, Z);
        opcode = OP_R; mem_bus.mem_ready = 1'b0;
        #1;
        chk("ra_fetch", FET_W);
        #1;
        reset = 1'b1;
        #1;
        chk("ra_dropped", Z);
        @(negedge clk);
        reset = 1'b0;

        step("il_idle",   OP_BAD, 3'b000, 0, 1, Z);
        step("il_fetch",  OP_BAD, 3'b000, 0, 1, FET);
        step("il_decode", OP_BAD, 3'b000, 0, 1, DEC);
`ifdef ILLEGAL_TRAP_EN
        step("il_halt",   OP_BAD, 3'b000, 0, 1, HALT_IL);
        step("il_stuck",  OP_R,   3'b000, 0, 1, HALT_IL);
`else
        step("il_nop_wb", OP_BAD, 3'b000, 0, 1, WB_NOP);
        step("il_next",   OP_R,   3'b000, 0, 1, FET);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/core_control_fsm.md
# core_control_fsm

Multi-cycle control sequencer for the RV32I core datapath. It steps each instruction through fetch, decode, execute, memory and writeback states. It drives the program-counter write enable and the 2-bit PC source select (PCPlus4 / PCTarget / ALUResult), and it handles a ready-based handshake with the shared instruction/data memory port. It sits between the instruction register and the datapath: one PC update per retired instruction, and a sticky halt on fault.

## Interface
- WAIT_LIMIT, 255: consecutive memory-wait cycles tolerated before timeout halt.
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- opcode  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request; held until mem_ready
- mem_we  out  1  write access; valid with mem_req
- adr_src  out  1  0 = PC, 1 = ALUResult address
- ir_write  out  1  latch instruction register
- pc_write  out  1  PC register enable
- pc_src  out  2  00 PCPlus4, 01 PCTarget, 10 ALUResult
- reg_write  out  1  register-file write enable
- result_src  out  2  00 ALU, 01 memory data, 10 PCPlus4
- alu_src_b  out  1  0 = rs2, 1 = immediate
- alu_op  out  2  00 add, 01 subtract, 10 decode by funct
- halted  out  1  core stopped (sticky until reset)
- mem_timeout  out  1  halt cause was a memory wait timeout
- illegal  out  1  halt cause was an undefined opcode (only with ILLEGAL_TRAP_EN)

## Operation
- States: IDLE, FETCH, DECODE, EXEC, ALUWB, MEMADR, MEMREAD, MEMWB, MEMWRITE, BRANCH, JAL, JALR, HALT.
- Outputs are a Moore decode of state, except:
  - ir_write and the MEMWRITE pc_write are qualified by mem_ready.
  - BRANCH pc_src is qualified by zero/funct3.
- IDLE: all outputs 0; moves to FETCH unconditionally.
- FETCH: mem_req=1, adr_src=0. On mem_ready: ir_write=1, go to DECODE.
- DECODE: classifies opcode.
  - 0110011 -> EXEC with alu_src_b=0.
  - 0010011 -> EXEC with alu_src_b=1.
  - 0000011/0100011 -> MEMADR.
  - 1100011 -> BRANCH.
  - 1101111 -> JAL.
  - 1100111 -> JALR.
- EXEC: alu_op=10 -> ALUWB.
- ALUWB: reg_write=1, result_src=00, pc_write=1, pc_src=00 -> FETCH.
- MEMADR: alu_src_b=1, alu_op=00. Goes to MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: mem_req=1, adr_src=1; on mem_ready -> MEMWB.
- MEMWB: reg_write=1, result_src=01, pc_write=1, pc_src=00 -> FETCH.
- MEMWRITE: mem_req=1, mem_we=1, adr_src=1. On mem_ready: pc_write=1, pc_src=00, go to FETCH.
- BRANCH: alu_op=01, pc_write=1 -> FETCH.
  - taken = (funct3==000 & zero) | (funct3==001 & ~zero).
  - pc_src=01 if taken, else 00.
  - Any other funct3 is not taken.
- JAL: reg_write=1, result_src=10, pc_write=1, pc_src=01 -> FETCH.
- JALR: alu_src_b=1, alu_op=00, reg_write=1, result_src=10, pc_write=1, pc_src=10 -> FETCH.
- Wait counter (8 bits minimum, saturating):
  - Counts cycles with mem_req=1 and mem_ready=0; clears on mem_ready or on leaving a memory state.
  - Reaching WAIT_LIMIT -> HALT with mem_timeout=1.
- HALT: all enables 0, halted=1; exits only on reset.
- pc_write asserts exactly once per instruction, never in FETCH/DECODE.

## Timing
- Reset: state=IDLE; every output 0, including halted, mem_timeout and illegal. Effect is immediate (asynchronous).
- Reset mid-access drops mem_req in the same cycle; the pending access is abandoned.
- Cycles per instruction with zero-wait memory:
  - R/I: 4.
  - load: 5.
  - store: 4.
  - branch/jal/jalr: 3.
- Each memory wait cycle adds 1.
- mem_ready while mem_req=0 is ignored.
- mem_ready in the same cycle as the WAIT_LIMIT-th wait cycle counts as completion, not timeout.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - An unlisted opcode in DECODE -> HALT with illegal=1.
  - The illegal output is present.
- Undefined:
  - An unlisted opcode is a NOP: DECODE -> ALUWB with reg_write forced 0, so the PC advances by 4.
  - The illegal output is tied 0.

## Structure
- Package core_ctrl_pkg holds:
  - state_t enum.
  - Opcode localparams.
  - pc_src_t enum (PC_PLUS4, PC_TARGET, PC_ALU).
  - result_src_t enum.
  - alu_op constants.
- One sub-module, instr_class_decode: combinational opcode -> instruction-class enum plus illegal flag. It is used by DECODE.

## Test plan
- Reset, then R-type with mem_ready=1 always -> pc_write high only in cycle 4, pc_src=00; reg_write with result_src=00.
- beq with zero=1 -> in BRANCH cycle pc_src=01, pc_write=1. bne with zero=1 -> pc_src=00.
- lw with mem_ready delayed 3 cycles in MEMREAD -> mem_req held 4 cycles; MEMWB result_src=01; 8 cycles total.
- jalr -> pc_src=10, result_src=10, reg_write=1 in cycle 3.
- WAIT_LIMIT=4, mem_ready stuck 0 in FETCH -> halted=1 and mem_timeout=1 after 4 wait cycles; reset clears both.
- Opcode 0000000 -> with ILLEGAL_TRAP_EN: illegal=1, halted=1. Without: PC advances by 4 and reg_write stays 0.
